decode_stage_hs: RTL

//  Parametrised, flow-controlled MIPS decode stage for the 5-stage CPU; sits between fetch and execute.

---
 rtl/mips_isa_pkg.sv | 86 ++++++++
 rtl/decode_stage_hs_if.sv | 39 +++
 rtl/decode_ctrl.sv | 110 +++++++++++
 rtl/decode_stage_hs.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcode/funct codes, ALU op codes and decode control bundle
package mips_isa_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type function codes
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2a;
   localparam logic [5:0] F_SLTU = 6'h2b;

   // ALU operation encoding shared with the execute stage
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_SLTU = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_NOR  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;
   localparam logic [3:0] ALU_XOR  = 4'd11;

   // Branch types
   localparam logic [3:0] B_BNE = 4'b0000;
   localparam logic [3:0] B_BEQ = 4'b0001;

   typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT}      imm_kind_e;
   typedef enum logic [1:0] {SRC1_RS, SRC1_SA, SRC1_PC}         src1_sel_e;
   typedef enum logic [1:0] {SRC2_RT, SRC2_IMM, SRC2_EIGHT}     src2_sel_e;
   typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_R31} dst_sel_e;

   typedef struct packed {
      logic [3:0] aluop;
      imm_kind_e  imm_kind;
      src1_sel_e  src1_sel;
      src2_sel_e  src2_sel;
      dst_sel_e   dst_sel;
      logic       wen;
      logic       is_load;
      logic       dramen;
      logic [3:0] dramwen;
      logic       is_b;
      logic       is_j;
      logic       is_jr;
      logic [3:0] b_type;
      logic       rs_used;
      logic       rt_used;
   } ctrl_t;

   // A do-nothing instruction: ADD with no side effects
   function automatic ctrl_t ctrl_nop();
      ctrl_t c;
      c       = '0;
      c.aluop = ALU_ADD;
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_hs_if.sv
// rtl/decode_stage_hs_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_stage_hs_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RA_W   = 5
) ();
   logic              fe_valid;
   logic              fe_ready;
   logic [31:0]       fe_inst;
   logic [PC_W-1:0]   fe_pc;

   logic              de_valid;
   logic              ex_ready;
   logic [3:0]        de_aluop;
   logic [DATA_W-1:0] de_alusrc1;
   logic [DATA_W-1:0] de_alusrc2;
   logic [DATA_W-1:0] de_rt_data;
   logic              de_is_load;
   logic              de_wen;
   logic              de_dramen;
   logic [3:0]        de_dramwen;
   logic [RA_W-1:0]   de_regdst;

   // Decode stage view
   modport master (
      input  fe_valid, fe_inst, fe_pc, ex_ready,
      output fe_ready,
      output de_valid, de_aluop, de_alusrc1, de_alusrc2, de_rt_data,
      output de_is_load, de_wen, de_dramen, de_dramwen, de_regdst
   );

   // Neighbouring fetch/execute view
   modport slave (
      output fe_valid, fe_inst, fe_pc, ex_ready,
      input  fe_ready,
      input  de_valid, de_aluop, de_alusrc1, de_alusrc2, de_rt_data,
      input  de_is_load, de_wen, de_dramen, de_dramwen, de_regdst
   );
endinterface

// File: rtl/decode_ctrl.sv
// rtl/decode_ctrl.sv - combinational opcode/funct to control bundle decoder
module decode_ctrl
   import mips_isa_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output ctrl_t      ctrl_o
);

   function automatic ctrl_t r_alu(input logic [3:0] aluop);
      ctrl_t c;
      c         = ctrl_nop();
      c.aluop   = aluop;
      c.rs_used = 1'b1;
      c.rt_used = 1'b1;
      c.wen     = 1'b1;
      c.dst_sel = DST_RD;
      return c;
   endfunction

   function automatic ctrl_t r_shift(input logic [3:0] aluop);
      ctrl_t c;
      c          = ctrl_nop();
      c.aluop    = aluop;
      c.src1_sel = SRC1_SA;
      c.rt_used  = 1'b1;
      c.wen      = 1'b1;
      c.dst_sel  = DST_RD;
      return c;
   endfunction

   function automatic ctrl_t i_alu(input logic [3:0] aluop, input imm_kind_e kind);
      ctrl_t c;
      c          = ctrl_nop();
      c.aluop    = aluop;
      c.imm_kind = kind;
      c.src2_sel = SRC2_IMM;
      c.rs_used  = 1'b1;
      c.wen      = 1'b1;
      c.dst_sel  = DST_RT;
      return c;
   endfunction

   // Map opcode/funct to control; anything unrecognised stays a NOP
   always_comb begin
      ctrl_o = ctrl_nop();
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               F_ADD, F_ADDU: ctrl_o = r_alu(ALU_ADD);
               F_SUB, F_SUBU: ctrl_o = r_alu(ALU_SUB);
               F_AND:         ctrl_o = r_alu(ALU_AND);
               F_OR:          ctrl_o = r_alu(ALU_OR);
               F_XOR:         ctrl_o = r_alu(ALU_XOR);
               F_NOR:         ctrl_o = r_alu(ALU_NOR);
               F_SLT:         ctrl_o = r_alu(ALU_SLT);
               F_SLTU:        ctrl_o = r_alu(ALU_SLTU);
               F_SLL:         ctrl_o = r_shift(ALU_SLL);
               F_SRL:         ctrl_o = r_shift(ALU_SRL);
               F_SRA:         ctrl_o = r_shift(ALU_SRA);
               F_JR: begin
                  ctrl_o.is_jr   = 1'b1;
                  ctrl_o.rs_used = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDIU: ctrl_o = i_alu(ALU_ADD, IMM_SEXT);
         OP_SLTI:           ctrl_o = i_alu(ALU_SLT, IMM_SEXT);
         OP_SLTIU:          ctrl_o = i_alu(ALU_SLTU, IMM_SEXT);
         OP_ANDI:           ctrl_o = i_alu(ALU_AND, IMM_ZEXT);
         OP_ORI:            ctrl_o = i_alu(ALU_OR, IMM_ZEXT);
         OP_XORI:           ctrl_o = i_alu(ALU_XOR, IMM_ZEXT);
         OP_LUI: begin
            ctrl_o         = i_alu(ALU_LUI, IMM_ZEXT);
            ctrl_o.rs_used = 1'b0;
         end
         OP_LW: begin
            ctrl_o         = i_alu(ALU_ADD, IMM_SEXT);
            ctrl_o.is_load = 1'b1;
            ctrl_o.dramen  = 1'b1;
         end
         OP_SW: begin
            ctrl_o.imm_kind = IMM_SEXT;
            ctrl_o.src2_sel = SRC2_IMM;
            ctrl_o.rs_used  = 1'b1;
            ctrl_o.rt_used  = 1'b1;
            ctrl_o.dramen   = 1'b1;
            ctrl_o.dramwen  = 4'b1111;
         end
         OP_BEQ, OP_BNE: begin
            ctrl_o.aluop   = ALU_SUB;
            ctrl_o.rs_used = 1'b1;
            ctrl_o.rt_used = 1'b1;
            ctrl_o.is_b    = 1'b1;
            ctrl_o.b_type  = (op_i == OP_BEQ) ? B_BEQ : B_BNE;
         end
         OP_J: ctrl_o.is_j = 1'b1;
         OP_JAL: begin
            ctrl_o.is_j     = 1'b1;
            ctrl_o.src1_sel = SRC1_PC;
            ctrl_o.src2_sel = SRC2_EIGHT;
            ctrl_o.wen      = 1'b1;
            ctrl_o.dst_sel  = DST_R31;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - flow-controlled MIPS decode stage with forwarding and load-use interlock
module decode_stage_hs
   import mips_isa_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int RA_W      = 5,
   parameter int FWD_EN    = 1,
   parameter int INTERLOCK = 1
) (
   input  logic              clk,
   input  logic              reset,
   decode_stage_hs_if.master hs,
   input  logic              flush,
   output logic [RA_W-1:0]   raddr1,
   output logic [RA_W-1:0]   raddr2,
   input  logic [DATA_W-1:0] rdata1,
   input  logic [DATA_W-1:0] rdata2,
   input  logic              ex_fwd_wen,
   input  logic [RA_W-1:0]   ex_fwd_addr,
   input  logic [DATA_W-1:0] ex_fwd_data,
   input  logic              wb_fwd_wen,
   input  logic [RA_W-1:0]   wb_fwd_addr,
   input  logic [DATA_W-1:0] wb_fwd_data,
   output logic              de_is_b,
   output logic              de_is_j,
   output logic              de_is_jr,
   output logic [3:0]        de_b_type,
   output logic [15:0]       de_b_offset,
   output logic [25:0]       de_j_index,
   output logic [DATA_W-1:0] de_jr_target
);

   ctrl_t             ctrl;
   logic [RA_W-1:0]   rs_a, rt_a, regdst_d;
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext, src1_d, src2_d;
   logic              stall, fire;

   logic              de_valid_q;
   logic [3:0]        de_aluop_q;
   logic [DATA_W-1:0] de_alusrc1_q, de_alusrc2_q, de_rt_data_q;
   logic              de_is_load_q, de_wen_q, de_dramen_q;
   logic [3:0]        de_dramwen_q;
   logic [RA_W-1:0]   de_regdst_q;

   decode_ctrl u_ctrl (
      .op_i    (hs.fe_inst[31:26]),
      .funct_i (hs.fe_inst[5:0]),
      .ctrl_o  (ctrl)
   );

   assign rs_a   = RA_W'(hs.fe_inst[25:21]);
   assign rt_a   = RA_W'(hs.fe_inst[20:16]);
   assign raddr1 = rs_a;
   assign raddr2 = rt_a;

   // Operand bypass: register 0 reads zero, the younger EX result beats WB
   always_comb begin
      rs_val = rdata1;
      rt_val = rdata2;
      if (FWD_EN != 0) begin
         if (ex_fwd_wen && ex_fwd_addr == rs_a)      rs_val = ex_fwd_data;
         else if (wb_fwd_wen && wb_fwd_addr == rs_a) rs_val = wb_fwd_data;
         if (ex_fwd_wen && ex_fwd_addr == rt_a)      rt_val = ex_fwd_data;
         else if (wb_fwd_wen && wb_fwd_addr == rt_a) rt_val = wb_fwd_data;
      end
      if (rs_a == '0) rs_val = '0;
      if (rt_a == '0) rt_val = '0;
   end

   // Immediate extension, ALU source selection and destination register
   always_comb begin
      imm_ext = (ctrl.imm_kind == IMM_SEXT) ?
                {{(DATA_W-16){hs.fe_inst[15]}}, hs.fe_inst[15:0]} :
                {{(DATA_W-16){1'b0}}, hs.fe_inst[15:0]};
      case (ctrl.src1_sel)
         SRC1_SA: src1_d = {{(DATA_W-5){1'b0}}, hs.fe_inst[10:6]};
         SRC1_PC: src1_d = DATA_W'(hs.fe_pc);
         default: src1_d = rs_val;
      endcase
      case (ctrl.src2_sel)
         SRC2_IMM:   src2_d = imm_ext;
         SRC2_EIGHT: src2_d = DATA_W'(8);
         default:    src2_d = rt_val;
      endcase
      case (ctrl.dst_sel)
         DST_RD:  regdst_d = RA_W'(hs.fe_inst[15:11]);
         DST_RT:  regdst_d = rt_a;
         DST_R31: regdst_d = RA_W'(5'd31);
         default: regdst_d = '0;
      endcase
   end

   // A load still sitting in the pipeline register cannot be bypassed yet
   assign stall = (INTERLOCK != 0) && de_valid_q && de_is_load_q && (de_regdst_q != '0) &&
                  ((de_regdst_q == rs_a && ctrl.rs_used) || (de_regdst_q == rt_a && ctrl.rt_used));

   assign hs.fe_ready = (~de_valid_q | hs.ex_ready) & ~stall & ~flush;
   assign fire        = hs.fe_valid & hs.fe_ready;

   assign de_is_b      = fire & ctrl.is_b;
   assign de_is_j      = fire & ctrl.is_j;
   assign de_is_jr     = fire & ctrl.is_jr;
   assign de_b_type    = ctrl.b_type;
   assign de_b_offset  = hs.fe_inst[15:0];
   assign de_j_index   = hs.fe_inst[25:0];
   assign de_jr_target = rs_val;

   // Pipeline register: flush kills, fire loads, a taken output without refill becomes a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         de_valid_q   <= 1'b0;
         de_aluop_q   <= '0;
         de_alusrc1_q <= '0;
         de_alusrc2_q <= '0;
         de_rt_data_q <= '0;
         de_is_load_q <= 1'b0;
         de_wen_q     <= 1'b0;
         de_dramen_q  <= 1'b0;
         de_dramwen_q <= '0;
         de_regdst_q  <= '0;
      end else if (flush) begin
         de_valid_q <= 1'b0;
      end else if (fire) begin
         de_valid_q   <= 1'b1;
         de_aluop_q   <= ctrl.aluop;
         de_alusrc1_q <= src1_d;
         de_alusrc2_q <= src2_d;
         de_rt_data_q <= rt_val;
         de_is_load_q <= ctrl.is_load;
         de_wen_q     <= ctrl.wen;
         de_dramen_q  <= ctrl.dramen;
         de_dramwen_q <= ctrl.dramwen;
         de_regdst_q  <= regdst_d;
      end else if (hs.ex_ready) begin
         de_valid_q <= 1'b0;
      end
   end

   assign hs.de_valid   = de_valid_q;
   assign hs.de_aluop   = de_aluop_q;
   assign hs.de_alusrc1 = de_alusrc1_q;
   assign hs.de_alusrc2 = de_alusrc2_q;
   assign hs.de_rt_data = de_rt_data_q;
   assign hs.de_is_load = de_is_load_q;
   assign hs.de_wen     = de_wen_q;
   assign hs.de_dramen  = de_dramen_q;
   assign hs.de_dramwen = de_dramwen_q;
   assign hs.de_regdst  = de_regdst_q;

endmodule
